// File: rtl/fb_scan_arbiter_if.sv
// Bundles the arbiter's pixel/write/SRAM signals; slave is the arbiter's view,
// master is the surrounding logic (scan generator, drawing logic and sram_io).
interface fb_scan_arbiter_if;
  logic        pix_ce;
  logic [18:0] scan_addr;
  logic        scan_active;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;
  logic        clear_req;
  logic        busy_clear;
  logic        sram_wren;
  logic [18:0] sram_addr;
  logic [15:0] sram_d;
  logic [15:0] sram_q;
  logic        pix_r;
  logic        pix_g;
  logic        pix_b;

  modport master (
    output pix_ce, scan_addr, scan_active, wr_valid, wr_addr, wr_data, clear_req, sram_q,
    input  wr_ready, busy_clear, sram_wren, sram_addr, sram_d, pix_r, pix_g, pix_b
  );

  modport slave (
    input  pix_ce, scan_addr, scan_active, wr_valid, wr_addr, wr_data, clear_req, sram_q,
    output wr_ready, busy_clear, sram_wren, sram_addr, sram_d, pix_r, pix_g, pix_b
  );
endinterface

// File: rtl/fb_scan_arbiter.sv
// Shares one SRAM port between VGA scan-out reads and queued pixel writes, clearing the
// framebuffer after reset. Define FBARB_STATS_EN to add the stall_cnt write-stall counter.
module fb_scan_arbiter #(
  parameter int unsigned FB_WORDS    = 416800,
  parameter logic [15:0] CLEAR_VALUE = 16'd0,
  parameter int unsigned WFIFO_DEPTH = 4,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FBARB_STATS_EN
  output logic [15:0]      stall_cnt,
`endif
  fb_scan_arbiter_if.slave bus
);
  localparam int unsigned   PtrW     = $clog2(WFIFO_DEPTH);
  localparam logic [18:0]   FbEnd    = 19'(FB_WORDS);
  localparam logic [18:0]   FbLast   = 19'(FB_WORDS - 1);
  localparam logic [PtrW:0] FifoFull = (PtrW + 1)'(WFIFO_DEPTH);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e      state_q, state_d;
  logic [18:0] clear_addr_q, clear_addr_d;
  logic        sram_wren_q, sram_wren_d;
  logic [18:0] sram_addr_q, sram_addr_d;
  logic [15:0] sram_d_q, sram_d_d;
  logic [2:0]  pix_q, pix_d;

  logic [18:0]     fifo_addr [WFIFO_DEPTH];
  logic [15:0]     fifo_data [WFIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            fifo_full, fifo_empty, wr_ready, push, pop, flush;
  logic            rd_slot, rd_act, scan_in_range;
  logic [18:0]     head_addr;
  logic [RD_LAT:0] pipe_vld_q, pipe_act_q;
  logic            unused_sram_q;

  // Full is judged on the registered count, so a pop never frees a slot in the same cycle.
  assign fifo_full     = (count_q == FifoFull);
  assign fifo_empty    = (count_q == '0);
  assign wr_ready      = (state_q == StRun) && !fifo_full;
  assign push          = bus.wr_valid && wr_ready;
  assign scan_in_range = (bus.scan_addr < FbEnd);
  assign head_addr     = fifo_addr[rd_ptr_q];
  assign unused_sram_q = ^bus.sram_q[15:3];

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    sram_wren_d  = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_d_d     = sram_d_q;
    flush        = 1'b0;
    pop          = 1'b0;
    rd_slot      = 1'b0;
    rd_act       = 1'b0;
    case (state_q)
      StClear: begin
        sram_wren_d = 1'b1;
        sram_addr_d = clear_addr_q;
        sram_d_d    = CLEAR_VALUE;
        if (clear_addr_q == FbLast) state_d = StRun;
        else clear_addr_d = clear_addr_q + 19'd1;
      end
      StRun: begin
        if (bus.clear_req) begin
          flush        = 1'b1;
          state_d      = StClear;
          clear_addr_d = '0;
        end else if (bus.pix_ce) begin
          rd_slot     = 1'b1;
          rd_act      = bus.scan_active && scan_in_range;
          sram_addr_d = scan_in_range ? bus.scan_addr : '0;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          // Out-of-range entries burn their slot without touching the SRAM.
          if (head_addr < FbEnd) begin
            sram_wren_d = 1'b1;
            sram_addr_d = head_addr;
            sram_d_d    = fifo_data[rd_ptr_q];
          end
        end
      end
      default: state_d = StClear;
    endcase

    if (state_d == StClear) pix_d = 3'b000;
    else if (pipe_vld_q[RD_LAT]) pix_d = pipe_act_q[RD_LAT] ? bus.sram_q[2:0] : 3'b000;
    else pix_d = pix_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StClear;
      clear_addr_q <= '0;
      sram_wren_q  <= 1'b0;
      sram_addr_q  <= '0;
      sram_d_q     <= '0;
      pix_q        <= '0;
      pipe_vld_q   <= '0;
      pipe_act_q   <= '0;
    end else begin
      state_q       <= state_d;
      clear_addr_q  <= clear_addr_d;
      sram_wren_q   <= sram_wren_d;
      sram_addr_q   <= sram_addr_d;
      sram_d_q      <= sram_d_d;
      pix_q         <= pix_d;
      pipe_vld_q[0] <= rd_slot;
      pipe_act_q[0] <= rd_act;
      for (int i = 1; i <= int'(RD_LAT); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_act_q[i] <= pipe_act_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) count_q <= count_q + (PtrW + 1)'(1);
      else if (pop && !push) count_q <= count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= bus.wr_addr;
      fifo_data[wr_ptr_q] <= bus.wr_data;
    end
  end

`ifdef FBARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (bus.wr_valid && !wr_ready && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

  assign bus.wr_ready   = wr_ready;
  assign bus.busy_clear = (state_q == StClear);
  assign bus.sram_wren  = sram_wren_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_d     = sram_d_q;
  assign bus.pix_r      = pix_q[2];
  assign bus.pix_g      = pix_q[1];
  assign bus.pix_b      = pix_q[0];
endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Bench for fb_scan_arbiter (FB_WORDS=16, WFIFO_DEPTH=4, RD_LAT=1): directed scenarios plus
// random traffic, checked against a queue-based transaction model and a 1-cycle SRAM model.
module tb_fb_scan_arbiter;
  localparam int unsigned Words = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_scan_arbiter_if bus ();
`ifdef FBARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  fb_scan_arbiter #(
    .FB_WORDS(16), .CLEAR_VALUE(16'd0), .WFIFO_DEPTH(4), .RD_LAT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef FBARB_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .bus(bus)
  );

  // SRAM with one cycle of read latency.
  logic [15:0] sram_mem [Words];
  initial for (int i = 0; i < int'(Words); i++) sram_mem[i] = 16'hFFFF;
  always @(posedge clk) begin
    if (bus.sram_wren) sram_mem[bus.sram_addr[3:0]] <= bus.sram_d;
    bus.sram_q <= sram_mem[bus.sram_addr[3:0]];
  end

  // Reference model: transaction-level view of what the port should do each clock.
  typedef struct packed { logic [18:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed { logic [31:0] due; logic [2:0] rgb; } pend_t;
  wr_t         m_fifo[$];
  pend_t       m_pend[$];
  logic [15:0] m_mem [Words];
  bit          m_clearing = 1'b1;
  int unsigned m_cidx = 0, m_cyc = 0;
  logic        exp_wren = 1'b0;
  logic [18:0] exp_addr = '0;
  logic [15:0] exp_d = '0;
  logic [2:0]  exp_pix = '0;
  logic [15:0] exp_stall = '0;

  always @(posedge clk) begin : model
    bit    ready, push, inr;
    wr_t   nw, head;
    pend_t np;
    if (rst) begin
      m_clearing = 1'b1; m_cidx = 0; m_fifo.delete(); m_pend.delete();
      exp_wren = 1'b0; exp_addr = '0; exp_d = '0; exp_pix = '0; exp_stall = '0;
    end else begin
      m_cyc++;
      ready = !m_clearing && (m_fifo.size() < 4);
      push  = bus.wr_valid && ready;
      if (bus.wr_valid && !ready && exp_stall != 16'hFFFF) exp_stall++;
      exp_wren = 1'b0;
      if (m_clearing) begin
        exp_wren = 1'b1; exp_addr = 19'(m_cidx); exp_d = 16'd0; m_mem[m_cidx] = 16'd0;
        if (m_cidx == Words - 1) m_clearing = 1'b0;
        else m_cidx++;
      end else if (bus.clear_req) begin
        m_fifo.delete(); m_pend.delete(); m_clearing = 1'b1; m_cidx = 0; push = 1'b0;
      end else if (bus.pix_ce) begin
        inr = bus.scan_addr < Words;
        exp_addr = inr ? bus.scan_addr : 19'd0;
        np.due = m_cyc + 2;
        np.rgb = (bus.scan_active && inr) ? m_mem[bus.scan_addr[3:0]][2:0] : 3'b000;
        m_pend.push_back(np);
      end else if (m_fifo.size() > 0) begin
        head = m_fifo.pop_front();
        if (head.addr < Words) begin
          exp_wren = 1'b1; exp_addr = head.addr; exp_d = head.data;
          m_mem[head.addr[3:0]] = head.data;
        end
      end
      if (push) begin
        nw.addr = bus.wr_addr; nw.data = bus.wr_data;
        m_fifo.push_back(nw);
      end
      if (m_clearing) exp_pix = 3'b000;
      else while (m_pend.size() > 0 && m_pend[0].due <= m_cyc) begin
        exp_pix = m_pend[0].rgb;
        void'(m_pend.pop_front());
      end
    end
  end

  int checks = 0;
  int failures = 0;

  function automatic logic [40:0] obs_vec();
    return {bus.sram_wren, bus.sram_addr, bus.sram_d, bus.wr_ready, bus.busy_clear,
            bus.pix_r, bus.pix_g, bus.pix_b};
  endfunction

  function automatic logic [40:0] exp_vec();
    return {exp_wren, exp_addr, exp_d, (!m_clearing && m_fifo.size() < 4), m_clearing, exp_pix};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    bus.pix_ce = ~bus.pix_ce;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    checks++;
    if (obs_vec() !== {1'b0, 19'd0, 16'd0, 1'b0, 1'b1, 3'b000}) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", obs_vec(), {1'b0, 19'd0, 16'd0, 1'b0, 1'b1, 3'b000});
    end
`ifdef FBARB_STATS_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_stall got=%h exp=0000", stall_cnt);
    end
`endif
  endtask

  task automatic test_clear();
    rst = 1'b0;
    for (int i = 0; i < int'(Words); i++) begin
      cycle();
      checks++;
      if ({bus.sram_wren, bus.sram_addr, bus.sram_d, bus.busy_clear} !==
          {1'b1, 19'(i), 16'd0, (i < int'(Words) - 1)}) begin
        failures++;
        $display("FAIL clear_write i=%0d got wren=%b addr=%0d d=%h busy=%b", i, bus.sram_wren,
                 bus.sram_addr, bus.sram_d, bus.busy_clear);
      end
    end
    cycle();
    checks++;
    if ({bus.sram_wren, bus.busy_clear, bus.wr_ready} !== 3'b001) begin
      failures++;
      $display("FAIL clear_done got wren=%b busy=%b ready=%b exp 0 0 1", bus.sram_wren,
               bus.busy_clear, bus.wr_ready);
    end
  endtask

  task automatic test_write_read();
    if (!bus.pix_ce) cycle();
    bus.wr_valid = 1'b1; bus.wr_addr = 19'd5; bus.wr_data = 16'h0005;
    cycle();
    bus.wr_valid = 1'b0;
    cycle();
    checks++;
    if ({bus.sram_wren, bus.sram_addr, bus.sram_d} !== {1'b1, 19'd5, 16'h0005}) begin
      failures++;
      $display("FAIL write_issue got wren=%b addr=%0d d=%h exp 1 5 0005", bus.sram_wren,
               bus.sram_addr, bus.sram_d);
    end
    bus.scan_addr = 19'd5; bus.scan_active = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      bus.scan_active = 1'b0;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL write_read_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({bus.pix_r, bus.pix_g, bus.pix_b} !== 3'b101) begin
      failures++; $display("FAIL pixel_rgb got=%b%b%b exp=101", bus.pix_r, bus.pix_g, bus.pix_b);
    end
  endtask

  task automatic test_fifo_full();
    bit saw_full = 1'b0;
    bit prev_ce;
    for (int i = 0; i < 16; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 19'($urandom_range(0, 15));
      bus.wr_data  = 16'($urandom);
      prev_ce = bus.pix_ce;
      cycle();
      if (!bus.wr_ready) saw_full = 1'b1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL fifo_full_model i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      checks++;
      if (prev_ce && bus.sram_wren !== 1'b0) begin
        failures++; $display("FAIL write_in_read_slot i=%0d got wren=%b exp=0", i, bus.sram_wren);
      end
    end
    bus.wr_valid = 1'b0;
    checks++;
    if (saw_full !== 1'b1) begin
      failures++; $display("FAIL fifo_backpressure got ready_low=%b exp=1", saw_full);
    end
`ifdef FBARB_STATS_EN
    checks++;
    if (stall_cnt !== exp_stall) begin
      failures++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
    end
`endif
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL drain_model i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_clear_req();
    if (!bus.pix_ce) cycle();
    for (int k = 0; k < 6; k++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 19'(k + 1); bus.wr_data = 16'hA000 + 16'(k);
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL queue_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
    bus.wr_valid = 1'b0;
    bus.clear_req = 1'b1;
    cycle();
    bus.clear_req = 1'b0;
    checks++;
    if ({bus.sram_wren, bus.busy_clear} !== 2'b01) begin
      failures++;
      $display("FAIL clear_req_start got wren=%b busy=%b exp 0 1", bus.sram_wren, bus.busy_clear);
    end
    for (int i = 0; i < int'(Words); i++) begin
      cycle();
      checks++;
      if ({bus.sram_wren, bus.sram_addr, bus.sram_d} !== {1'b1, 19'(i), 16'd0}) begin
        failures++;
        $display("FAIL reclear_write i=%0d got wren=%b addr=%0d d=%h", i, bus.sram_wren,
                 bus.sram_addr, bus.sram_d);
      end
    end
    cycle();
    checks++;
    if (obs_vec() !== exp_vec() || bus.busy_clear !== 1'b0) begin
      failures++; $display("FAIL reclear_done got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_out_of_range();
    if (!bus.pix_ce) cycle();
    bus.wr_valid = 1'b1; bus.wr_addr = 19'd0; bus.wr_data = 16'h0007;
    cycle();
    bus.wr_addr = 19'd16; bus.wr_data = 16'hFFFF;
    cycle();
    bus.wr_valid = 1'b0;
    checks++;
    if ({bus.sram_wren, bus.sram_addr, bus.wr_ready} !== {1'b1, 19'd0, 1'b1}) begin
      failures++;
      $display("FAIL oor_accept got wren=%b addr=%0d ready=%b exp 1 0 1", bus.sram_wren,
               bus.sram_addr, bus.wr_ready);
    end
    cycle();
    cycle();
    checks++;
    if ({bus.sram_wren, bus.wr_ready} !== 2'b01) begin
      failures++;
      $display("FAIL oor_no_write got wren=%b ready=%b exp 0 1", bus.sram_wren, bus.wr_ready);
    end
    bus.scan_addr = 19'd0; bus.scan_active = 1'b1;
    cycle();
    bus.scan_addr = 19'd20;
    cycle();
    cycle();
    checks++;
    if ({bus.pix_r, bus.pix_g, bus.pix_b, bus.sram_wren, bus.sram_addr} !==
        {3'b111, 1'b0, 19'd0}) begin
      failures++;
      $display("FAIL oor_read_addr got rgb=%b%b%b wren=%b addr=%0d exp 111 0 0", bus.pix_r,
               bus.pix_g, bus.pix_b, bus.sram_wren, bus.sram_addr);
    end
    bus.scan_active = 1'b0;
    cycle();
    cycle();
    checks++;
    if ({bus.pix_r, bus.pix_g, bus.pix_b} !== 3'b000) begin
      failures++; $display("FAIL oor_black got=%b%b%b exp=000", bus.pix_r, bus.pix_g, bus.pix_b);
    end
  endtask

  task automatic test_rst_mid_clear();
    bus.clear_req = 1'b1;
    cycle();
    bus.clear_req = 1'b0;
    for (int i = 0; i < 9; i++) cycle();
    checks++;
    if ({bus.sram_wren, bus.sram_addr} !== {1'b1, 19'd8}) begin
      failures++;
      $display("FAIL mid_clear_pos got wren=%b addr=%0d exp 1 8", bus.sram_wren, bus.sram_addr);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if (obs_vec() !== {1'b0, 19'd0, 16'd0, 1'b0, 1'b1, 3'b000}) begin
      failures++; $display("FAIL mid_clear_reset got=%h", obs_vec());
    end
    cycle();
    checks++;
    if ({bus.sram_wren, bus.sram_addr} !== {1'b1, 19'd0}) begin
      failures++;
      $display("FAIL clear_restart got wren=%b addr=%0d exp 1 0", bus.sram_wren, bus.sram_addr);
    end
    for (int i = 0; i < int'(Words); i++) begin
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL restart_model i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.wr_valid    = 1'($urandom_range(0, 1));
      bus.wr_addr     = 19'($urandom_range(0, 19));
      bus.wr_data     = 16'($urandom);
      bus.scan_addr   = 19'($urandom_range(0, 19));
      bus.scan_active = 1'($urandom_range(0, 3) != 0);
      bus.clear_req   = ($urandom_range(0, 59) == 0);
      rst             = ($urandom_range(0, 199) == 0);
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL random_model i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0; bus.wr_valid = 1'b0; bus.clear_req = 1'b0;
`ifdef FBARB_STATS_EN
    checks++;
    if (stall_cnt !== exp_stall) begin
      failures++; $display("FAIL random_stall got=%0d exp=%0d", stall_cnt, exp_stall);
    end
`endif
  endtask

  initial begin
    bus.pix_ce = 1'b0; bus.scan_addr = '0; bus.scan_active = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.clear_req = 1'b0;
    test_reset();
    test_clear();
    test_write_read();
    test_fifo_full();
    test_clear_req();
    test_out_of_range();
    test_rst_mid_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
